// File: rtl/core_mem_pkg.sv
// Shared types for the core memory scheduler: FSM states and bus-owner encoding.
package core_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } mem_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FETCH,
        SRC_LSU_RD,
        SRC_LSU_WR
    } mem_src_e;

endpackage

// File: rtl/core_mem_sched_if.sv
// External memory bus as seen by the scheduler (master) and the memory (slave).
interface core_mem_sched_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] byte_en;
    logic [DW-1:0]   wdata;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   rdata;

    modport master (
        output req, we, addr, byte_en, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, byte_en, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arb_select.sv
// Fixed-priority pick (write > LSU read > fetch) with a fetch anti-starvation override.
module mem_arb_select
    import core_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_fetch_req,
    input  logic     i_lsu_rd_req,
    input  logic     i_lsu_wr_req,
    input  logic     i_grant_stb,
    output mem_src_e o_winner
);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;

    always_comb begin
        o_winner = SRC_NONE;
        if (i_fetch_req && (starve_cnt_q == CNT_MAX)) begin
            o_winner = SRC_FETCH;
        end else if (i_lsu_wr_req) begin
            o_winner = SRC_LSU_WR;
        end else if (i_lsu_rd_req) begin
            o_winner = SRC_LSU_RD;
        end else if (i_fetch_req) begin
            o_winner = SRC_FETCH;
        end
    end

    // The strobe only fires on enabled IDLE cycles, so it doubles as the clock enable.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (i_grant_stb) begin
            if (o_winner == SRC_FETCH) begin
                starve_cnt_d = '0;
            end else if (i_fetch_req && (starve_cnt_q != CNT_MAX)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/core_mem_sched.sv
// Shares one external memory bus between fetch read, LSU read and LSU write,
// one outstanding transaction at a time, and drives the core stall line.
module core_mem_sched
    import core_mem_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    output logic            o_stall,
    input  logic            i_fetch_read,
    input  logic [AW-1:0]   i_fetch_addr,
    output logic [DW-1:0]   o_fetch_data,
    output logic            o_fetch_ack,
    input  logic            i_lsu_read,
    input  logic [AW-1:0]   i_r_lsu_addr,
    output logic [DW-1:0]   o_r_lsu_data,
    output logic            o_lsu_ack,
    input  logic            i_lsu_write,
    input  logic [AW-1:0]   i_w_lsu_addr,
    input  logic [DW/8-1:0] i_w_lsu_byte_en,
    input  logic [DW-1:0]   i_w_lsu_data,
    output logic            o_lsu_wack,
    core_mem_sched_if.master mem
);
    mem_state_e      state_q, state_d;
    mem_src_e        src_q, src_d;
    mem_src_e        winner;
    logic            grant_stb;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   fetch_data_q, fetch_data_d;
    logic [DW-1:0]   lsu_data_q, lsu_data_d;
    logic            fetch_ack_q, fetch_ack_d;
    logic            lsu_ack_q, lsu_ack_d;
    logic            wack_q, wack_d;

    mem_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fetch_req  (i_fetch_read),
        .i_lsu_rd_req (i_lsu_read),
        .i_lsu_wr_req (i_lsu_write),
        .i_grant_stb  (grant_stb),
        .o_winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        fetch_data_d = fetch_data_q;
        lsu_data_d   = lsu_data_q;
        fetch_ack_d  = 1'b0;
        lsu_ack_d    = 1'b0;
        wack_d       = 1'b0;
        grant_stb    = 1'b0;
        if (!i_clk_en) begin
            // Frozen cycle: pulses stretch rather than drop.
            fetch_ack_d = fetch_ack_q;
            lsu_ack_d   = lsu_ack_q;
            wack_d      = wack_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (winner != SRC_NONE) begin
                        grant_stb = 1'b1;
                        src_d     = winner;
                        req_d     = 1'b1;
                        state_d   = ST_REQ;
                        we_d      = 1'b0;
                        be_d      = '1;
                        wdata_d   = '0;
                        case (winner)
                            SRC_LSU_WR: begin
                                we_d    = 1'b1;
                                addr_d  = i_w_lsu_addr;
                                be_d    = i_w_lsu_byte_en;
                                wdata_d = i_w_lsu_data;
                            end
                            SRC_LSU_RD: addr_d = i_r_lsu_addr;
                            default:    addr_d = i_fetch_addr;
                        endcase
                    end
                end
                ST_REQ: begin
                    if (mem.gnt) begin
                        req_d = 1'b0;
                        if (we_q) begin
                            wack_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (mem.rvalid) begin
                        state_d = ST_IDLE;
                        if (src_q == SRC_FETCH) begin
                            fetch_data_d = mem.rdata;
                            fetch_ack_d  = 1'b1;
                        end else begin
                            lsu_data_d = mem.rdata;
                            lsu_ack_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_NONE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            fetch_data_q <= '0;
            lsu_data_q   <= '0;
            fetch_ack_q  <= 1'b0;
            lsu_ack_q    <= 1'b0;
            wack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            fetch_data_q <= fetch_data_d;
            lsu_data_q   <= lsu_data_d;
            fetch_ack_q  <= fetch_ack_d;
            lsu_ack_q    <= lsu_ack_d;
            wack_q       <= wack_d;
        end
    end

    assign mem.req      = req_q;
    assign mem.we       = we_q;
    assign mem.addr     = addr_q;
    assign mem.byte_en  = be_q;
    assign mem.wdata    = wdata_q;
    assign o_fetch_data = fetch_data_q;
    assign o_r_lsu_data = lsu_data_q;
    assign o_fetch_ack  = fetch_ack_q;
    assign o_lsu_ack    = lsu_ack_q;
    assign o_lsu_wack   = wack_q;
    assign o_stall      = (i_lsu_read & ~lsu_ack_q) | (i_lsu_write & ~wack_q);

endmodule

// File: tb/tb_core_mem_sched.sv
// Directed bench for core_mem_sched with a small configurable-latency memory responder.
module tb_core_mem_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        o_stall;
    logic        i_fetch_read;
    logic [31:0] i_fetch_addr;
    logic [31:0] o_fetch_data;
    logic        o_fetch_ack;
    logic        i_lsu_read;
    logic [31:0] i_r_lsu_addr;
    logic [31:0] o_r_lsu_data;
    logic        o_lsu_ack;
    logic        i_lsu_write;
    logic [31:0] i_w_lsu_addr;
    logic [3:0]  i_w_lsu_byte_en;
    logic [31:0] i_w_lsu_data;
    logic        o_lsu_wack;

    int errors = 0;
    int checks = 0;

    logic [31:0] log_addr[$];
    logic        log_we[$];

    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          wcnt      = 0;
    int          rv_wait   = 0;
    bit          rv_pending = 1'b0;
    bit          en_seen    = 1'b0;
    logic [31:0] rv_addr    = '0;
    logic        gnt_auto   = 1'b0;
    logic        rv_auto    = 1'b0;
    logic        spur_rv    = 1'b0;
    logic [31:0] rdata_auto = '0;

    core_mem_sched_if #(.AW(32), .DW(32)) bus ();

    assign bus.gnt    = gnt_auto;
    assign bus.rvalid = rv_auto | spur_rv;
    assign bus.rdata  = rdata_auto;

    core_mem_sched #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clk_en        (clk_en),
        .o_stall         (o_stall),
        .i_fetch_read    (i_fetch_read),
        .i_fetch_addr    (i_fetch_addr),
        .o_fetch_data    (o_fetch_data),
        .o_fetch_ack     (o_fetch_ack),
        .i_lsu_read      (i_lsu_read),
        .i_r_lsu_addr    (i_r_lsu_addr),
        .o_r_lsu_data    (o_r_lsu_data),
        .o_lsu_ack       (o_lsu_ack),
        .i_lsu_write     (i_lsu_write),
        .i_w_lsu_addr    (i_w_lsu_addr),
        .i_w_lsu_byte_en (i_w_lsu_byte_en),
        .i_w_lsu_data    (i_w_lsu_data),
        .o_lsu_wack      (o_lsu_wack),
        .mem             (bus)
    );

    wire [137:0] all_outs = {bus.req, bus.we, bus.addr, bus.byte_en, bus.wdata, o_stall,
                             o_fetch_ack, o_lsu_ack, o_lsu_wack, o_fetch_data, o_r_lsu_data};

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
    endfunction

    // Memory model: grants after gnt_delay cycles of req, returns rdata rv_delay cycles
    // after the grant; only advances after posedges the DUT actually consumed.
    initial begin
        forever begin
            @(posedge clk);
            en_seen = clk_en;
            @(negedge clk);
            if (rst) begin
                gnt_auto   = 1'b0;
                rv_auto    = 1'b0;
                rv_pending = 1'b0;
                wcnt       = 0;
            end else if (en_seen) begin
                rv_auto = 1'b0;
                if (rv_pending) begin
                    if (rv_wait == 0) begin
                        rv_auto    = 1'b1;
                        rdata_auto = mem_word(rv_addr);
                        rv_pending = 1'b0;
                    end else begin
                        rv_wait--;
                    end
                end
                gnt_auto = 1'b0;
                if (bus.req) begin
                    if (wcnt == gnt_delay) begin
                        gnt_auto = 1'b1;
                        wcnt     = 0;
                        log_addr.push_back(bus.addr);
                        log_we.push_back(bus.we);
                        if (!bus.we) begin
                            rv_pending = 1'b1;
                            rv_wait    = rv_delay;
                            rv_addr    = bus.addr;
                        end
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_en = 1'b1;
        i_fetch_read = 1'b0; i_fetch_addr = '0;
        i_lsu_read = 1'b0;   i_r_lsu_addr = '0;
        i_lsu_write = 1'b0;  i_w_lsu_addr = '0; i_w_lsu_byte_en = '0; i_w_lsu_data = '0;
        tick();
        tick();
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        checks++;
        rst = 1'b0;
        tick();
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_req: got %b expected 0", bus.req);
        end
        checks++;
        $display("test_reset done");
    endtask

    task automatic test_fetch_single();
        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h0000_0100;
        tick();
        if ({bus.req, bus.we, bus.addr, bus.byte_en} !== {1'b1, 1'b0, 32'h0000_0100, 4'hF}) begin
            errors++;
            $display("FAIL fetch_bus_n1: got req=%b we=%b addr=%h be=%h expected 1 0 00000100 f",
                     bus.req, bus.we, bus.addr, bus.byte_en);
        end
        checks++;
        tick();
        if (o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack_n2: got %b expected 0", o_fetch_ack);
        end
        checks++;
        tick();
        if ({o_fetch_ack, o_fetch_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL fetch_ack_n3: got ack=%b data=%h expected 1 deadbeef", o_fetch_ack, o_fetch_data);
        end
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_stall: got %b expected 0", o_stall);
        end
        checks++;
        i_fetch_read = 1'b0;
        tick();
        if ({o_fetch_ack, o_fetch_data, bus.req} !== {1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL fetch_after: got ack=%b data=%h req=%b expected 0 deadbeef 0",
                     o_fetch_ack, o_fetch_data, bus.req);
        end
        checks++;
        $display("test_fetch_single done");
    endtask

    task automatic test_simultaneous();
        bit done = 1'b0;
        bit wr_seen = 1'b0;
        log_addr.delete();
        log_we.delete();
        i_fetch_read = 1'b1; i_fetch_addr = 32'h0000_0180;
        i_lsu_read   = 1'b1; i_r_lsu_addr = 32'h0000_0200;
        i_lsu_write  = 1'b1; i_w_lsu_addr = 32'h0000_0300;
        i_w_lsu_byte_en = 4'b0011; i_w_lsu_data = 32'h0000_1234;
        #1;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL simul_stall_start: got %b expected 1", o_stall);
        end
        checks++;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (bus.req && bus.we && !wr_seen) begin
                wr_seen = 1'b1;
                if ({bus.byte_en, bus.wdata} !== {4'b0011, 32'h0000_1234}) begin
                    errors++;
                    $display("FAIL simul_wr_fields: got be=%b data=%h expected 0011 00001234",
                             bus.byte_en, bus.wdata);
                end
                checks++;
            end
            if (o_lsu_wack) i_lsu_write = 1'b0;
            if (o_lsu_ack) begin
                if ({o_r_lsu_data, o_stall} !== {32'hFFFF_FDFF, 1'b0}) begin
                    errors++;
                    $display("FAIL simul_lsu_ack: got data=%h stall=%b expected fffffdff 0",
                             o_r_lsu_data, o_stall);
                end
                checks++;
                i_lsu_read = 1'b0;
            end else if (i_lsu_read) begin
                if (o_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_stall_hold: got %b expected 1 (cycle %0d)", o_stall, i);
                end
                checks++;
            end
            if (o_fetch_ack) begin
                if (o_fetch_data !== 32'hFFFF_FE7F) begin
                    errors++;
                    $display("FAIL simul_fetch_data: got %h expected fffffe7f", o_fetch_data);
                end
                checks++;
                i_fetch_read = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL simul_timeout: got no fetch ack expected one within 40 cycles");
        end
        checks++;
        if (log_addr.size() !== 3) begin
            errors++;
            $display("FAIL simul_count: got %0d transactions expected 3", log_addr.size());
        end
        checks++;
        if ({log_we[0], log_addr[0], log_we[1], log_addr[1], log_we[2], log_addr[2]} !==
            {1'b1, 32'h300, 1'b0, 32'h200, 1'b0, 32'h180}) begin
            errors++;
            $display("FAIL simul_order: got %b:%h %b:%h %b:%h expected 1:300 0:200 0:180",
                     log_we[0], log_addr[0], log_we[1], log_addr[1], log_we[2], log_addr[2]);
        end
        checks++;
        $display("test_simultaneous done");
    endtask

    task automatic test_starvation();
        int  n_wack = 0;
        bit  done = 1'b0;
        log_addr.delete();
        log_we.delete();
        i_fetch_read = 1'b1; i_fetch_addr = 32'h0000_0400;
        i_lsu_write  = 1'b1; i_w_lsu_addr = 32'h0000_0500;
        i_w_lsu_byte_en = 4'hF; i_w_lsu_data = 32'hAAAA_5555;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (o_lsu_wack) n_wack++;
            if (o_fetch_ack) begin
                i_fetch_read = 1'b0;
                i_lsu_write  = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL starve_timeout: got no fetch ack expected one within 80 cycles");
            i_fetch_read = 1'b0;
            i_lsu_write  = 1'b0;
        end
        checks++;
        if (n_wack !== 4) begin
            errors++;
            $display("FAIL starve_writes: got %0d write acks before fetch expected 4", n_wack);
        end
        checks++;
        if ({log_we[3], log_addr[3], log_we[4], log_addr[4]} !== {1'b1, 32'h500, 1'b0, 32'h400}) begin
            errors++;
            $display("FAIL starve_order: got %b:%h %b:%h expected 1:500 0:400 (size %0d)",
                     log_we[3], log_addr[3], log_we[4], log_addr[4], log_addr.size());
        end
        checks++;
        tick();
        tick();
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL starve_quiet: got req=%b expected 0", bus.req);
        end
        checks++;
        $display("test_starvation done");
    endtask

    task automatic test_slow_bus();
        int n_ack = 0;
        gnt_delay = 3;
        rv_delay  = 5;
        i_lsu_read = 1'b1;
        i_r_lsu_addr = 32'h0000_0600;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ({bus.req, bus.addr} !== {1'b1, 32'h0000_0600}) begin
                errors++;
                $display("FAIL slow_req_stable: got req=%b addr=%h expected 1 00000600 (wait %0d)",
                         bus.req, bus.addr, k);
            end
            checks++;
            if (k == 0) begin
                if (o_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL slow_stall: got %b expected 1", o_stall);
                end
                checks++;
            end
            if (k == 1) spur_rv = 1'b1;
            if (k == 2) spur_rv = 1'b0;
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_lsu_ack) begin
                n_ack++;
                if (o_r_lsu_data !== 32'hFFFF_F9FF) begin
                    errors++;
                    $display("FAIL slow_data: got %h expected fffff9ff", o_r_lsu_data);
                end
                checks++;
                i_lsu_read = 1'b0;
            end
        end
        if (n_ack !== 1) begin
            errors++;
            $display("FAIL slow_ack_count: got %0d acks expected 1", n_ack);
        end
        checks++;
        gnt_delay = 0;
        rv_delay  = 0;
        $display("test_slow_bus done");
    endtask

    task automatic test_clk_en();
        int          n_ack = 0;
        logic        en_applied;
        logic [65:0] prev;
        logic [65:0] now;
        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h0000_0700;
        clk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            prev = {bus.req, o_fetch_ack, o_fetch_data, bus.addr};
            en_applied = clk_en;
            tick();
            now = {bus.req, o_fetch_ack, o_fetch_data, bus.addr};
            if (!en_applied) begin
                if (now !== prev) begin
                    errors++;
                    $display("FAIL clken_hold: got %h expected %h (cycle %0d)", now, prev, i);
                end
                checks++;
            end else if (o_fetch_ack) begin
                n_ack++;
                if (o_fetch_data !== 32'hFFFF_F8FF) begin
                    errors++;
                    $display("FAIL clken_data: got %h expected fffff8ff", o_fetch_data);
                end
                checks++;
                i_fetch_read = 1'b0;
            end
            clk_en = ~clk_en;
        end
        if (n_ack !== 1) begin
            errors++;
            $display("FAIL clken_ack_count: got %0d acks expected 1", n_ack);
        end
        checks++;
        clk_en = 1'b1;
        i_fetch_read = 1'b0;
        tick();
        $display("test_clk_en done");
    endtask

    task automatic test_reset_in_rsp();
        rv_delay = 10;
        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h0000_0800;
        tick();
        tick();
        #2;
        rst = 1'b1;
        i_fetch_read = 1'b0;
        #1;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rsp_reset_outputs: got %h expected 0", all_outs);
        end
        checks++;
        tick();
        rst = 1'b0;
        rv_delay = 0;
        spur_rv = 1'b1;
        tick();
        tick();
        spur_rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ({o_fetch_ack, o_lsu_ack, bus.req} !== 3'b000) begin
                errors++;
                $display("FAIL rsp_reset_no_ack: got fack=%b lack=%b req=%b expected 0 0 0",
                         o_fetch_ack, o_lsu_ack, bus.req);
            end
            checks++;
            tick();
        end
        $display("test_reset_in_rsp done");
    endtask

    initial begin
        test_reset();
        test_fetch_single();
        test_simultaneous();
        test_starvation();
        test_slow_bus();
        test_clk_en();
        test_reset_in_rsp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
